// File: rtl/lcd_pkg.sv
// Shared definitions for the energy display sequencer: sequencer states,
// LCD word constants and digit count.
package lcd_pkg;

  localparam int N_DIGITS = 10;
  localparam int BIN_W    = 32;
  localparam int BCD_W    = 40;

  // LCD words are {rs, d[7:0]}
  localparam logic [8:0] W_ADDR   = 9'h080;
  localparam logic [8:0] W_SPACE  = 9'h120;
  localparam logic [8:0] W_DIGIT  = 9'h130;
  localparam logic [8:0] W_CHAR_W = 9'h157;
  localparam logic [8:0] W_CHAR_H = 9'h168;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_WAIT_FREE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } seq_state_e;

  function automatic logic [8:0] digit_word(input logic [3:0] d);
    return W_DIGIT | {5'd0, d};
  endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Iterative double-dabble converter, one binary bit per cycle.
// done pulses once the 32 shifts have completed; bcd then holds until the next start.
module bin2bcd_dd
  import lcd_pkg::*;
(
  input  logic             clock,
  input  logic             internal_reset,
  input  logic             start,
  input  logic [31:0]      bin,
  output logic [39:0]      bcd,
  output logic             done
);

  logic [BIN_W-1:0] sh;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] adj;
  logic [5:0]       cnt;
  logic             run;

  // add-3 correction on every nibble before the shift
  always_comb begin
    adj = acc;
    for (int i = 0; i < BCD_W / 4; i++)
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clock) begin
    if (internal_reset) begin
      sh   <= '0;
      acc  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh  <= bin;
        acc <= '0;
        cnt <= 6'd32;
        run <= 1'b1;
      end else if (run) begin
        acc <= {adj[BCD_W-2:0], sh[BIN_W-1]};
        sh  <= {sh[BIN_W-2:0], 1'b0};
        cnt <= cnt - 6'd1;
        if (cnt == 6'd1) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign bcd = acc;

endmodule

// File: rtl/energy_display_seq.sv
// Converts a latched Wh reading to decimal and streams the 13-word line
// "<addr><digits>Wh" to the LCD driver with a busy-flag handshake per word.
module energy_display_seq #(
  parameter int N_DIGITS = lcd_pkg::N_DIGITS
) (
  input  logic        clock,
  input  logic        internal_reset,
  input  logic [31:0] datobase,
  input  logic        update,
  input  logic        lcd_busy,
  output logic [8:0]  d_out,
  output logic        data_ready,
  output logic        seq_busy
);
  import lcd_pkg::*;

  localparam int N_WORDS = N_DIGITS + 3;
  localparam int IDX_W   = $clog2(N_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam logic [IDX_W-1:0] W_IDX    = IDX_W'(N_DIGITS + 1);

  seq_state_e       state, next_state;
  logic [31:0]      value;
  logic [IDX_W-1:0] idx;
  logic             pending;
  logic             start_q;
  logic [39:0]      bcd;
  logic             conv_done;
  logic             accept, advance, load;
  logic             nz;
  logic [8:0]       digit_w [N_DIGITS];
  logic [8:0]       word;

  bin2bcd_dd u_conv (
    .clock          (clock),
    .internal_reset (internal_reset),
    .start          (start_q),
    .bin            (value),
    .bcd            (bcd),
    .done           (conv_done)
  );

  assign accept  = (state == ST_IDLE) && (update || pending);
  assign load    = (state == ST_WAIT_FREE) && !lcd_busy;
  assign advance = (state == ST_WAIT_DONE) && !lcd_busy;

  // leading zeros blank to spaces; the units digit is always shown
  always_comb begin
    nz = 1'b0;
    for (int p = N_DIGITS - 1; p >= 0; p--) begin
      nz = nz | (bcd[4*p +: 4] != 4'd0);
      digit_w[p] = (nz || p == 0) ? digit_word(bcd[4*p +: 4]) : W_SPACE;
    end
    word = W_CHAR_H;
    if (idx == '0)         word = W_ADDR;
    else if (idx == W_IDX) word = W_CHAR_W;
    for (int i = 1; i <= N_DIGITS; i++)
      if (idx == IDX_W'(i)) word = digit_w[N_DIGITS - i];
  end

  always_ff @(posedge clock) begin
    if (internal_reset) state <= ST_IDLE;
    else                state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (update || pending) next_state = ST_CONVERT;
      ST_CONVERT:   if (conv_done) next_state = ST_WAIT_FREE;
      ST_WAIT_FREE: if (!lcd_busy) next_state = ST_SEND;
      // busy rising under us means the strobe is withheld and retried
      ST_SEND:      next_state = lcd_busy ? ST_WAIT_FREE : ST_WAIT_ACK;
      ST_WAIT_ACK:  if (lcd_busy) next_state = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!lcd_busy) next_state = (idx == LAST_IDX) ? ST_IDLE : ST_WAIT_FREE;
      default:      next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (internal_reset) begin
      value   <= '0;
      idx     <= '0;
      pending <= 1'b0;
      start_q <= 1'b0;
      d_out   <= '0;
    end else begin
      start_q <= accept;
      if (accept) begin
        value   <= datobase;
        idx     <= '0;
        pending <= 1'b0;
      end else if (update && state != ST_IDLE) begin
        pending <= 1'b1;
      end
      if (load) d_out <= word;
      if (advance && idx != LAST_IDX) idx <= idx + 1'b1;
    end
  end

  assign data_ready = (state == ST_SEND) && !lcd_busy;
  assign seq_busy   = (state != ST_IDLE);

endmodule
